// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_receiver
//  Description : Rebuilds DATA_W-bit characters from an LSB-first serial
//                stream framed by a one-cycle sync strobe, buffers them in a
//                small FIFO and offers them over a valid/ready handshake.
//                Sticky flags report framing errors and FIFO overruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              frame_error,
    output logic              overrun,
    input  logic              clear_flags,
    output logic [PTR_W:0]    fill_level
);

    localparam int             CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [PTR_W:0]   c_FULL     = (PTR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic [DATA_W-1:0]   w_push_char;
    logic                w_push;
    logic                w_frame_err_evt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                w_pop;
    logic                w_full;
    logic                w_push_ok;
    logic                w_drop;

    // Deserialiser state register: FSM state, bit position and partial character
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
        end
    end

    // Next-state logic: sample one bit per SHIFT cycle, push on the last bit,
    // and resynchronise on a strobe (error unless it lands on the last bit)
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_push_char     = r_shift;
        w_push          = 1'b0;
        w_frame_err_evt = 1'b0;
        w_push_char[r_bit_cnt] = serial_in;
        case (r_state)
            ST_IDLE: begin
                if (frame_sync) begin
                    w_state_next   = ST_SHIFT;
                    w_bit_cnt_next = '0;
                    w_shift_next   = '0;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt == c_LAST_BIT) begin
                    // Final bit is always kept; a coincident strobe starts the next frame
                    w_push         = 1'b1;
                    w_shift_next   = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = frame_sync ? ST_SHIFT : ST_IDLE;
                end else if (frame_sync) begin
                    w_frame_err_evt = 1'b1;
                    w_shift_next    = '0;
                    w_bit_cnt_next  = '0;
                end else begin
                    w_shift_next   = w_push_char;
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake decode; a full FIFO still accepts a push when it pops the same cycle
    assign w_pop     = (r_count != '0) && char_ready;
    assign w_full    = (r_count == c_FULL);
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // FIFO storage: write the completed character at the write pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[PTR_W'(i)] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_char;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (w_frame_err_evt) begin
                frame_error <= 1'b1;
            end else if (clear_flags) begin
                frame_error <= 1'b0;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    assign char_out   = r_mem[r_rd_ptr];
    assign char_valid = (r_count != '0);
    assign fill_level = r_count;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_frame_receiver
//  Description : Self-checking bench for serial_frame_receiver. A queue of
//                expected characters plus two flag bits model the receiver
//                at frame level; every cycle is compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              serial_in;
    logic              frame_sync;
    logic [DATA_W-1:0] char_out;
    logic              char_valid;
    logic              char_ready;
    logic              frame_error;
    logic              overrun;
    logic              clear_flags;
    logic [PTR_W:0]    fill_level;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [DATA_W-1:0] q[$];
    logic              m_err;
    logic              m_ovr;
    bit                rnd_mode;

    serial_frame_receiver #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .serial_in   (serial_in),
        .frame_sync  (frame_sync),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .clear_flags (clear_flags),
        .fill_level  (fill_level)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    // One clock cycle: drive inputs, advance the frame-level model, compare
    task automatic cycle(input logic sync, input logic sbit, input logic done,
                         input logic [DATA_W-1:0] ch, input logic ferr);
        logic pop;
        logic drop;
        int   pre;
        frame_sync = sync;
        serial_in  = sbit;
        if (rnd_mode) begin
            char_ready  = ($urandom_range(0, 2) != 0);
            clear_flags = ($urandom_range(0, 7) == 0);
        end
        pre = q.size();
        if (pre != 0) begin
            n_cmp++;
            if (char_out !== q[0]) begin
                n_bad++;
                $display("FAIL char_out: got %h want %h at %0t", char_out, q[0], $time);
            end
        end
        pop  = (pre != 0) && char_ready;
        drop = done && (pre == DEPTH) && !pop;
        @(posedge clock);
        if (pop) void'(q.pop_front());
        if (done && !drop) q.push_back(ch);
        if (ferr) m_err = 1'b1; else if (clear_flags) m_err = 1'b0;
        if (drop) m_ovr = 1'b1; else if (clear_flags) m_ovr = 1'b0;
        #1;
        n_cmp++;
        if (char_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL char_valid: got %b want %b at %0t", char_valid, (q.size() != 0), $time);
        end
        n_cmp++;
        if (fill_level !== (PTR_W + 1)'(q.size())) begin
            n_bad++;
            $display("FAIL fill_level: got %0d want %0d at %0t", fill_level, q.size(), $time);
        end
        n_cmp++;
        if (frame_error !== m_err) begin
            n_bad++;
            $display("FAIL frame_error: got %b want %b at %0t", frame_error, m_err, $time);
        end
        n_cmp++;
        if (overrun !== m_ovr) begin
            n_bad++;
            $display("FAIL overrun: got %b want %b at %0t", overrun, m_ovr, $time);
        end
    endtask

    // Whole frame: optional sync cycle, DATA_W bits LSB first
    task automatic send_frame(input logic [DATA_W-1:0] ch, input logic sync_first,
                              input logic sync_last, input logic ready_last);
        if (sync_first) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        for (int i = 0; i < DATA_W - 1; i++) cycle(1'b0, ch[i], 1'b0, ch, 1'b0);
        if (ready_last) char_ready = 1'b1;
        cycle(sync_last, ch[DATA_W-1], 1'b1, ch, 1'b0);
        if (ready_last) char_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({char_out, char_valid, frame_error, overrun, fill_level} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got out=%h v=%b fe=%b ov=%b fill=%0d want all 0",
                     char_out, char_valid, frame_error, overrun, fill_level);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        q.delete();
        m_err = 1'b0;
        m_ovr = 1'b0;
        idle(2);
    endtask

    task automatic test_single;
        char_ready = 1'b1;
        send_frame(8'h29, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (char_valid !== 1'b1 || char_out !== 8'h29) begin
            n_bad++;
            $display("FAIL single_char: got v=%b out=%h want v=1 out=29", char_valid, char_out);
        end
        idle(1);
        n_cmp++;
        if (char_valid !== 1'b0 || fill_level !== 3'd0 || frame_error !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL single_after: got v=%b fill=%0d fe=%b ov=%b want 0 0 0 0",
                     char_valid, fill_level, frame_error, overrun);
        end
    endtask

    task automatic test_overrun;
        logic [DATA_W-1:0] exp_ch;
        char_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send_frame(8'h41 + 8'(k), (k == 0), (k < 4), 1'b0);
        n_cmp++;
        if (fill_level !== 3'd4 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_full: got fill=%0d ov=%b want 4 1", fill_level, overrun);
        end
        char_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_ch = 8'h41 + 8'(k);
            n_cmp++;
            if (char_valid !== 1'b1 || char_out !== exp_ch) begin
                n_bad++;
                $display("FAIL overrun_pop: got v=%b out=%h want 1 %h", char_valid, char_out, exp_ch);
            end
            idle(1);
        end
        n_cmp++;
        if (fill_level !== 3'd0 || char_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_drain: got fill=%0d v=%b want 0 0", fill_level, char_valid);
        end
        clear_flags = 1'b1;
        idle(1);
        clear_flags = 1'b0;
    endtask

    task automatic test_frame_error;
        char_ready = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (frame_error !== 1'b1 || char_out !== 8'h5A || fill_level !== 3'd1) begin
            n_bad++;
            $display("FAIL frame_err: got fe=%b out=%h fill=%0d want 1 5a 1", frame_error, char_out, fill_level);
        end
        idle(2);
        clear_flags = 1'b1;
        idle(1);
        clear_flags = 1'b0;
        n_cmp++;
        if (frame_error !== 1'b0 || fill_level !== 3'd0) begin
            n_bad++;
            $display("FAIL frame_err_clear: got fe=%b fill=%0d want 0 0", frame_error, fill_level);
        end
    endtask

    task automatic test_wrap;
        char_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            idle(1);
            send_frame(8'($urandom), 1'b1, 1'b0, 1'b1);
            n_cmp++;
            if (fill_level !== 3'd3) begin
                n_bad++;
                $display("FAIL wrap_fill: got %0d want 3 (frame %0d)", fill_level, k);
            end
        end
        char_ready = 1'b1;
        idle(4);
    endtask

    task automatic test_reset_mid;
        char_ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({char_out, char_valid, frame_error, overrun, fill_level} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got out=%h v=%b fe=%b ov=%b fill=%0d want all 0",
                     char_out, char_valid, frame_error, overrun, fill_level);
        end
        q.delete();
        m_err = 1'b0;
        m_ovr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i & 1), 1'b0, '0, 1'b0);
        n_cmp++;
        if (char_valid !== 1'b0 || fill_level !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_no_sync: got v=%b fill=%0d want 0 0", char_valid, fill_level);
        end
    endtask

    task automatic test_clear_collision;
        logic [DATA_W-1:0] ch;
        char_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        ch = 8'hE7;
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DATA_W - 1; i++) cycle(1'b0, ch[i], 1'b0, ch, 1'b0);
        clear_flags = 1'b1;
        cycle(1'b0, ch[DATA_W-1], 1'b1, ch, 1'b0);
        clear_flags = 1'b0;
        n_cmp++;
        if (overrun !== 1'b1 || fill_level !== 3'd4) begin
            n_bad++;
            $display("FAIL clear_vs_drop: got ov=%b fill=%0d want 1 4", overrun, fill_level);
        end
        char_ready = 1'b1;
        idle(5);
        clear_flags = 1'b1;
        idle(1);
        clear_flags = 1'b0;
    endtask

    task automatic test_random;
        bit pending;
        bit b2b;
        int nb;
        logic [DATA_W-1:0] ch;
        pending  = 1'b0;
        rnd_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            if (!pending) idle($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) begin
                if (!pending) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
                nb = $urandom_range(0, DATA_W - 2);
                for (int i = 0; i < nb; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
                cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
                pending = 1'b1;
            end else begin
                ch  = 8'($urandom);
                b2b = ($urandom_range(0, 1) == 1) && (f != 59);
                send_frame(ch, !pending, b2b, 1'b0);
                pending = b2b;
            end
        end
        if (pending) send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        rnd_mode    = 1'b0;
        char_ready  = 1'b1;
        clear_flags = 1'b0;
        idle(6);
        n_cmp++;
        if (fill_level !== 3'd0) begin
            n_bad++;
            $display("FAIL random_drain: got fill=%0d want 0", fill_level);
        end
    endtask

    // Scenario sequence
    initial begin
        reset       = 1'b1;
        serial_in   = 1'b0;
        frame_sync  = 1'b0;
        char_ready  = 1'b0;
        clear_flags = 1'b0;
        rnd_mode    = 1'b0;
        m_err       = 1'b0;
        m_ovr       = 1'b0;
        test_reset();
        test_single();
        test_overrun();
        test_frame_error();
        test_wrap();
        test_reset_mid();
        test_clear_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive end of the encoder's serial link: rebuilds 8-bit characters from the 1-bit serial stream, using the encoder's frame strobe (op_when) as the boundary marker.
- Buffers completed characters in a small FIFO and hands them to the decrypter/Monitor side over a valid/ready handshake.
- Flags framing errors (strobe arriving mid-character) and overruns (FIFO full at character completion).

Parameters:
DATA_W, 8, character width in bits
DEPTH, 4, FIFO entries; power of two, at least 2
PTR_W, 2, log2(DEPTH)

Ports:
clock  input  1  single system clock; all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
serial_in  input  1  serial data from encoder; LSB first
frame_sync  input  1  one-cycle strobe from encoder (op_when); marks start of a character
char_out  output  DATA_W  head-of-FIFO character
char_valid  output  1  FIFO non-empty
char_ready  input  1  consumer accepts char_out when char_valid and char_ready are both high
frame_error  output  1  sticky; set on a framing error
overrun  output  1  sticky; set when a completed character is dropped
clear_flags  input  1  synchronous clear of frame_error and overrun
fill_level  output  PTR_W+1  number of FIFO entries in use

Behaviour:
- Reset (async assert, sync release):
  - char_out = 0, char_valid = 0, frame_error = 0, overrun = 0, fill_level = 0.
  - Shift register = 0, bit counter = 0, FSM = IDLE.
- FSM states: IDLE, SHIFT.
  - IDLE: serial_in is ignored. frame_sync = 1 -> SHIFT, bit counter = 0. No bit is sampled in the sync cycle.
  - SHIFT: each cycle samples serial_in into bit position [counter], then increments the counter.
  - When the counter reaches DATA_W-1 and that bit is sampled, the character is complete. It is pushed to the FIFO and the FSM returns to IDLE.
  - frame_sync = 1 while in SHIFT: the partial character is discarded, frame_error is set, and the counter restarts at 0 while staying in SHIFT (resynchronise to the new strobe).
  - frame_sync = 1 in the same cycle as the final bit: the final bit is taken and the push is kept. The FSM goes to SHIFT with counter 0, not IDLE (back-to-back frames). This is not an error.
- Frame timing and latency:
  - Nominal frame is 1 sync cycle + DATA_W data cycles.
  - A character pushed into an empty FIFO shows on char_out/char_valid on the cycle after the final bit is sampled: 1-cycle latency, registered outputs.
- FIFO:
  - Circular buffer with PTR_W-bit read/write pointers that wrap modulo DEPTH.
  - fill_level range is 0..DEPTH.
  - Pop happens on char_valid & char_ready. char_out always shows the entry at the read pointer, registered.
  - Push and pop in the same cycle: both happen and fill_level is unchanged. This holds when full; it also holds when empty only if an entry is present at the start of the cycle (no fall-through).
  - Push when full with no pop in that cycle: the new character is dropped, overrun is set, and stored contents are unchanged.
  - Pop when empty: ignored.
- Flags:
  - frame_error and overrun stay high until clear_flags or reset.
  - clear_flags and a new error event in the same cycle: the flag ends set (set wins).
- Reset mid-character or mid-handshake: the partial character and all FIFO contents are lost immediately. char_valid drops asynchronously.
- No decryption in this block. Its output feeds the existing decrypter unchanged.

Test Plan:
1. Reset, then frame_sync pulse followed by serial bits 1,0,0,1,0,1,0,0 (LSB first) with char_ready=1 -> char_out=8'h29 with char_valid high for 1 cycle, 1 cycle after the last bit; fill_level returns to 0; flags stay 0.
2. Five back-to-back frames (0x41,0x42,0x43,0x44,0x45) with char_ready=0, sync coinciding with each previous final bit -> fill_level=4; overrun=1 after the 5th frame. Then char_ready=1 -> the bench pops 0x41..0x44 in order, 0x45 is absent, and fill_level ends at 0.
3. frame_sync after 3 data bits of a frame, then a full 0x5A frame -> frame_error=1; exactly one character 0x5A is delivered; assert clear_flags -> frame_error=0 next cycle.
4. FIFO holding 3 entries with char_ready=1 held while a new frame completes -> the push and pop share a cycle, fill_level stays 3, and order is preserved across pointer wrap (run 10 frames, check the sequence).
5. Assert reset during bit 5 of a frame with 2 entries buffered -> all outputs go to 0 immediately. After release, serial_in toggling without frame_sync produces no character.
6. clear_flags asserted in the same cycle as an overrun drop -> overrun=1 afterwards (set wins).
